// File: rtl/sr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_pkg
// Description : Shared constants and FSM state type for the SR frequency
//               tracker: omega numerator, nominal harmonic centers, widths.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_pkg;

  // round(2*pi * 2^14): omega numerator for dt = 0.00025 s in Q14
  localparam int K_OMEGA_NUM = 102944;

  // Nominal OMEGA_DT of the first five SR harmonics
  localparam int OMEGA_CENTER_F0 = 196;
  localparam int OMEGA_CENTER_F1 = 354;
  localparam int OMEGA_CENTER_F2 = 514;
  localparam int OMEGA_CENTER_F3 = 643;
  localparam int OMEGA_CENTER_F4 = 823;

  // Divider dividend width and period counter width
  localparam int DIV_BITS = 17;
  localparam int CNT_BITS = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2,
    UPDATE  = 2'd3
  } sr_state_t;

endpackage
`default_nettype wire

// File: rtl/sr_period_divider.sv
`default_nettype none
// ============================================================================
// Module      : sr_period_divider
// Description : 17-bit unsigned restoring divider, one quotient bit per clk.
//               A start pulse loads operands; done pulses one clk after the
//               17th iteration, when the quotient is final.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_period_divider
  import sr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [DIV_BITS-1:0] i_dividend,
  input  logic [CNT_BITS-1:0] i_divisor,
  output logic                o_busy,
  output logic                o_done,
  output logic [DIV_BITS-1:0] o_quotient
);

  localparam int               c_ITER_W = $clog2(DIV_BITS + 1);
  localparam logic [c_ITER_W-1:0] c_ITERS = c_ITER_W'(DIV_BITS);

  // The remainder is always below the divisor, so it fits the divisor width;
  // the quotient register doubles as the dividend shift register.
  logic [CNT_BITS-1:0] r_rem;
  logic [DIV_BITS-1:0] r_quo;
  logic [CNT_BITS-1:0] r_div;
  logic [c_ITER_W-1:0] r_iter;
  logic                r_busy;
  logic                r_done;

  logic [CNT_BITS:0]   w_trial;
  logic [CNT_BITS:0]   w_diff;
  logic                w_fits;

  // Trial subtraction for the current quotient bit
  always_comb begin
    w_trial = {r_rem, r_quo[DIV_BITS-1]};
    w_diff  = w_trial - {1'b0, r_div};
    w_fits  = (w_trial >= {1'b0, r_div});
  end

  // Operand load, shift/subtract iterations and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_quo  <= i_dividend;
        r_div  <= i_divisor;
        r_iter <= c_ITERS;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_fits ? w_diff[CNT_BITS-1:0] : w_trial[CNT_BITS-1:0];
        r_quo  <= {r_quo[DIV_BITS-2:0], w_fits};
        r_iter <= r_iter - 1'b1;
        if (r_iter == c_ITER_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/sr_frequency_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sr_frequency_tracker
// Description : Measures the period of a sampled oscillator between rising
//               zero crossings and recovers its OMEGA_DT (Q14) as K / N,
//               with offset from the nominal center and a lock indication.
//               Optional macro SR_TRACK_IIR_EN: first-order smoothing of the
//               recovered omega (shift ALPHA_SHIFT); undefined = raw quotient.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_frequency_tracker
  import sr_pkg::*;
#(
  parameter int WIDTH        = 18,
  parameter int FRAC         = 14,
  parameter int OMEGA_CENTER = 196,
  parameter int MIN_PERIOD   = 100,
  parameter int MAX_PERIOD   = 1000,
  parameter int LOCK_COUNT   = 4,
  parameter int ALPHA_SHIFT  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] sample_in,
  output logic signed [WIDTH-1:0] omega_dt,
  output logic signed [WIDTH-1:0] drift_offset,
  output logic                    est_valid,
  output logic                    locked,
  output logic                    overrun
);

  localparam logic [CNT_BITS-1:0]     c_MIN_P    = CNT_BITS'(MIN_PERIOD);
  localparam logic [CNT_BITS-1:0]     c_MAX_P    = CNT_BITS'(MAX_PERIOD);
  localparam logic [CNT_BITS-1:0]     c_CNT_SAT  = CNT_BITS'(MAX_PERIOD + 1);
  localparam logic [DIV_BITS-1:0]     c_K        = DIV_BITS'(K_OMEGA_NUM);
  localparam logic signed [WIDTH-1:0] c_CENTER   = WIDTH'(OMEGA_CENTER);
  localparam int                      c_STREAK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [c_STREAK_W-1:0]   c_LOCK_N   = c_STREAK_W'(LOCK_COUNT);

  sr_state_t r_state;
  sr_state_t w_state_next;

  logic signed [WIDTH-1:0] r_prev_sample;
  logic [CNT_BITS-1:0]     r_count;
  logic [c_STREAK_W-1:0]   r_streak;
  logic [c_STREAK_W-1:0]   w_streak_inc;
  logic signed [WIDTH-1:0] r_omega;
  logic signed [WIDTH-1:0] r_drift;
  logic                    r_est_valid;
  logic                    r_locked;
  logic                    r_overrun;

  logic                    w_crossing;
  logic                    w_in_range;
  logic                    w_timeout;
  logic                    w_div_start;
  logic                    w_div_busy;
  logic                    w_div_done;
  logic [DIV_BITS-1:0]     w_quotient;
  logic signed [WIDTH-1:0] w_q;
  logic signed [WIDTH-1:0] w_omega_next;

  logic                    w_overrun_set;
  logic                    w_streak_clr;
  logic                    w_do_update;
  logic                    w_to_idle;

  // Rising zero crossing, qualified by the sample strobe
  always_comb begin
    w_crossing = clk_en && (r_prev_sample < 0) && (sample_in >= 0);
    w_in_range = (r_count >= c_MIN_P) && (r_count <= c_MAX_P);
    w_timeout  = (r_count == c_CNT_SAT);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and per-state control strobes
  always_comb begin
    w_state_next  = r_state;
    w_div_start   = 1'b0;
    w_overrun_set = 1'b0;
    w_streak_clr  = 1'b0;
    w_do_update   = 1'b0;
    w_to_idle     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_crossing) begin
          w_state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (w_crossing) begin
          if (w_in_range && !w_div_busy) begin
            w_div_start  = 1'b1;
            w_state_next = DIVIDE;
          end else begin
            w_streak_clr = 1'b1;
          end
        end else if (w_timeout) begin
          w_streak_clr = 1'b1;
          w_to_idle    = 1'b1;
          w_state_next = IDLE;
        end
      end
      DIVIDE: begin
        if (w_crossing) begin
          w_overrun_set = 1'b1;
        end
        if (w_div_done) begin
          w_state_next = UPDATE;
        end
      end
      UPDATE: begin
        w_do_update  = 1'b1;
        w_state_next = MEASURE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The current count is the period: the crossing sample itself was sample 1
  sr_period_divider u_divider (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (c_K),
    .i_divisor  (r_count),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  assign w_q = WIDTH'(w_quotient);

`ifdef SR_TRACK_IIR_EN
  logic                    r_first;
  logic signed [WIDTH:0]   w_diff;
  logic signed [WIDTH:0]   w_sum;

  // Smoothed omega; the first estimate after IDLE seeds the filter directly
  always_comb begin
    w_diff       = (WIDTH+1)'(w_q) - (WIDTH+1)'(r_omega);
    w_sum        = (WIDTH+1)'(r_omega) + (w_diff >>> ALPHA_SHIFT);
    w_omega_next = r_first ? w_q : w_sum[WIDTH-1:0];
  end

  // Seed flag: set after reset or timeout, cleared by the first update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b1;
    end else if (w_to_idle) begin
      r_first <= 1'b1;
    end else if (w_do_update) begin
      r_first <= 1'b0;
    end
  end
`else
  // Raw quotient is the estimate
  always_comb begin
    w_omega_next = w_q;
  end
`endif

  // Lock streak increment, saturating at the lock threshold
  always_comb begin
    w_streak_inc = (r_streak == c_LOCK_N) ? r_streak : r_streak + 1'b1;
  end

  // Sample history and period counter, advanced only on the sample strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_sample <= '0;
      r_count       <= '0;
    end else if (clk_en) begin
      r_prev_sample <= sample_in;
      if (w_crossing) begin
        r_count <= CNT_BITS'(1);
      end else if (r_count != c_CNT_SAT) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Estimate outputs, lock tracking and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_omega     <= c_CENTER;
      r_drift     <= '0;
      r_est_valid <= 1'b0;
      r_streak    <= '0;
      r_locked    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_est_valid <= w_do_update;
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
      if (w_streak_clr) begin
        r_streak <= '0;
        r_locked <= 1'b0;
      end else if (w_do_update) begin
        r_streak <= w_streak_inc;
        r_locked <= (w_streak_inc == c_LOCK_N);
      end
      if (w_do_update) begin
        r_omega <= w_omega_next;
        r_drift <= w_omega_next - c_CENTER;
      end
    end
  end

  assign omega_dt     = r_omega;
  assign drift_offset = r_drift;
  assign est_valid    = r_est_valid;
  assign locked       = r_locked;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sr_frequency_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_frequency_tracker
// Description : Directed self-checking bench for sr_frequency_tracker with
//               square-wave stimulus of chosen periods and hand-computed
//               estimates (K = 102944 divided by the period).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_frequency_tracker;

  logic               clk;
  logic               rst_n;
  logic               clk_en;
  logic signed [17:0] sample_in;
  logic signed [17:0] omega_dt;
  logic signed [17:0] drift_offset;
  logic               est_valid;
  logic               locked;
  logic               overrun;

  int n_cmp;
  int n_mis;
  int cyc;
  int est_count;
  int est_cyc;
  int last_cross;
  int qual_cross;

  sr_frequency_tracker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .sample_in    (sample_in),
    .omega_dt     (omega_dt),
    .drift_offset (drift_offset),
    .est_valid    (est_valid),
    .locked       (locked),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each estimate pulse and the edge that produced it
  always @(posedge clk) begin
    #1;
    if (est_valid === 1'b1) begin
      est_count = est_count + 1;
      est_cyc   = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_mis = n_mis + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic signed [17:0] s);
    @(negedge clk);
    clk_en    = 1'b1;
    sample_in = s;
  endtask

  // One period of p samples: crossing sample first, half high, half low;
  // gap idle clocks (strobe low) follow each sample.
  task automatic run_period(input int p, input int gap);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      if (i == 0) last_cross = cyc + 1;
      clk_en    = 1'b1;
      sample_in = (i < p / 2) ? 18'sd1000 : -18'sd1000;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        clk_en = 1'b0;
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    cyc       = 0;
    est_count = 0;
    est_cyc   = 0;
    last_cross = 0;
    qual_cross = 0;
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    sample_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_omega", omega_dt, 196);
    check("rst_drift", drift_offset, 0);
    check("rst_est_valid", est_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Period 526: three estimates, then lock on the fourth
    repeat (10) drive(-18'sd1000);
    repeat (4) run_period(526, 0);
    check("p526_count3", est_count, 3);
    check("p526_omega", omega_dt, 195);
    check("p526_drift", drift_offset, -1);
    check("p526_latency", est_cyc - last_cross, 19);
    check("p526_unlocked3", locked, 0);
    run_period(526, 0);
    check("p526_count4", est_count, 4);
    check("p526_locked4", locked, 1);

    // Period 400 then period 100 (minimum)
    run_period(400, 0);
    run_period(100, 0);
    check("p400_omega", omega_dt, 257);
    check("p400_drift", drift_offset, 61);
    run_period(99, 0);
    check("p100_count", est_count, 7);
    check("p100_omega", omega_dt, 1029);
    check("p100_drift", drift_offset, 833);
    check("p100_locked", locked, 1);

    // Period 99 is rejected: no estimate, lock drops, output held
    run_period(200, 0);
    check("p99_count", est_count, 7);
    check("p99_locked", locked, 0);
    check("p99_hold", omega_dt, 1029);

    // Period 200 estimate, then a gap long enough to time out
    run_period(1102, 0);
    check("p200_count", est_count, 8);
    check("p200_omega", omega_dt, 514);
    run_period(300, 0);
    check("idle_no_est", est_count, 8);
    check("idle_hold", omega_dt, 514);
    run_period(300, 0);
    check("p300_count", est_count, 9);
    check("p300_omega", omega_dt, 343);
    check("p300_drift", drift_offset, 147);

    // Period 1000 (maximum) is accepted
    run_period(1000, 0);
    run_period(100, 0);
    check("p1000_count", est_count, 11);
    check("p1000_omega", omega_dt, 102);
    check("p1000_drift", drift_offset, -94);
    check("pre_overrun", overrun, 0);

    // Extra crossing 5 clk into the divide: overrun, result still delivered
    @(negedge clk);
    qual_cross = cyc + 1;
    clk_en     = 1'b1;
    sample_in  = 18'sd1000;
    repeat (4) drive(-18'sd1000);
    drive(18'sd1000);
    repeat (74) drive(18'sd1000);
    repeat (75) drive(-18'sd1000);
    check("ovr_flag", overrun, 1);
    check("ovr_count", est_count, 12);
    check("ovr_omega", omega_dt, 1029);
    check("ovr_latency", est_cyc - qual_cross, 19);
    run_period(100, 0);
    check("ovr_next_omega", omega_dt, 686);
    check("ovr_next_drift", drift_offset, 490);
    check("ovr_sticky", overrun, 1);

    // Sparse strobe: only strobed samples count, divide still runs on clk
    run_period(200, 2);
    run_period(200, 2);
    check("sparse_count", est_count, 15);
    check("sparse_omega", omega_dt, 514);
    check("sparse_latency", est_cyc - last_cross, 19);
    check("sparse_locked", locked, 1);

    // Reset asserted in the middle of a divide
    drive(18'sd1000);
    repeat (5) drive(18'sd1000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_omega", omega_dt, 196);
    check("mid_rst_drift", drift_offset, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) drive(18'sd1000);
    check("post_rst_no_est", est_count, 15);
    check("post_rst_omega", omega_dt, 196);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
